hazard_ctrl_multi: RTL and testbench
====================================

// Module: hazard_ctrl_multi
// PURPOSE
//  Parametrised N-lane hazard controller for the superscalar 5-stage pipeline; successor to the fixed dual-lane unit.
//  Adds cross-lane forwarding, bundle-wide stall/flush, oldest-branch squash, memory-wait freeze,
//  and a registered scoreboard for one outstanding fixed-latency long op (mul/div).
//  Sits beside the pipeline registers; drives all stall/flush/forward selects.
// PARAMETERS
//  LANES     2   issue width; lane 0 = oldest in a bundle
//  LONG_LAT  4   long-op latency in cycles, range 2..15
//  LW        $clog2(LANES) or 1 if LANES==1; source-lane field width (derived)
// PORTS
//  clk          in   1          pipeline clock
//  rst_n        in   1          synchronous reset, active-low
//  rs1_d,rs2_d  in   LANES*5    D-stage sources, lane i at [5i+:5]
//  rd_d         in   LANES*5    D-stage destinations, for WAW check
//  rs1_e,rs2_e  in   LANES*5    E-stage sources
//  rd_e,rd_m,rd_w             in  LANES*5  destinations per stage
//  regwrite_e,regwrite_m,regwrite_w  in  LANES  write enables per stage
//  is_load_e    in   LANES      E lane holds a load
//  long_e       in   LANES      E lane holds a long op
//  br_taken_e   in   LANES      E lane resolved taken branch/jump
//  mem_wait     in   1          data memory not ready
//  fwd_a_e,fwd_b_e  out LANES*(2+LW)  per lane: [1:0] stage (00 RF, 10 M, 01 W), [2+:LW] source lane
//  stall_f,stall_d,stall_e,stall_m  out 1  hold the stage register
//  flush_d,flush_e,flush_w          out 1  bubble into the stage register
//  squash_e     out  LANES      kill E lanes younger than the taken branch
//  br_lane      out  LW         index of oldest taken lane
//  long_done    out  1          long result valid this cycle
//  long_rd      out  5          destination of the completing long op
// BEHAVIOUR
//  Combinational outputs are driven from inputs plus registered state; state is busy_v, busy_rd[4:0], cnt[3:0].
//  Forwarding, per lane operand with rs!=0:
//   - Search M-stage lanes first, youngest (highest index) first, requiring regwrite_m && rd_m==rs.
//   - If no M match, search W-stage lanes the same way.
//   - Otherwise select 00.
//   - The source-lane field is 0 when the stage is 00.
//  Intra-bundle RAW/WAW is prevented by issue logic and is not checked here.
//  Priority, highest first:
//   P1 mem_wait:
//    - Assert stall_f, stall_d, stall_e, stall_m and flush_w.
//    - Force all other stalls/flushes to 0.
//    - Freeze cnt.
//   P2 any br_taken_e:
//    - Set br_lane = lowest set index b.
//    - Set squash_e[i] = (i>b).
//    - Assert flush_d and flush_e; assert no stalls.
//   P3 structural, scoreboard or load-use:
//    - Stall conditions:
//      - structural: any long_e while busy_v && cnt>1;
//      - scoreboard: busy_v && any D rs1/rs2/rd ==busy_rd, with busy_rd!=0;
//      - load-use: any is_load_e lane with rd_e!=0 matching any D rs.
//    - Response: stall_f=stall_d=1 and flush_e=1.
//    - A structural stall also asserts stall_e instead of flush_e, holding the long op.
//  Scoreboard:
//   - Load: at an edge where long_e[i], regwrite_e[i], rd_e!=0, lane not squashed and no P1/structural stall.
//     - Set busy_v=1, busy_rd=rd_e[i], cnt=LONG_LAT.
//     - Only the oldest such lane loads.
//   - Count: cnt decrements each non-P1 cycle.
//   - Complete: long_done=1 and long_rd=busy_rd while busy_v && cnt==1.
//     - busy_v clears at that edge, unless a new long op loads at the same edge (the new op wins).
//   - No bypass from the long unit: a D consumer is released the cycle after long_done.
//  Reset (rst_n low at an edge):
//   - busy_v=0, cnt=0, busy_rd=0; a pending completion is dropped, with no long_done.
//   - While rst_n is low: all stalls 0, flush_d=flush_e=1, fwd 00, squash_e=0, br_lane=0, long_done=0, long_rd=0.
// CONFIGURATION
//  HAZ_PERF_EN defined:
//   - Adds outputs perf_stall_cyc[31:0] (P1 or P3 cycles) and perf_flush_cnt[31:0] (P2 cycles).
//   - Both are cleared by reset and wrap at 2^32.
//  HAZ_PERF_EN undefined: the ports and counters are absent.
// TESTING
//  1 Forwarding: lane1 rs1_e=5; rd_m lane0=5 and lane1=5, both written -> fwd_a_e lane1 = {src 1, 10}.
//  2 Load-use: lane0 load rd_e=7; lane1 rs2_d=7 -> stall_f=stall_d=flush_e=1 for exactly 1 cycle.
//  3 Branch over load-use: br_taken_e=2'b11 with a load-use hit -> br_lane=0, squash_e=2'b10, flush_d=flush_e=1, no stall.
//  4 Long op, LONG_LAT=4: rd 9 issues at cycle t with rs1_d=9 -> stall_d t+1..t+4; long_done,long_rd=9 at t+4; released t+5.
//  5 Memory wait: mem_wait held 3 cycles at t+2 -> all four stalls plus flush_w; long_done moves to t+7.
//  6 Reset mid-op: rst_n low at t+2 -> no long_done, busy_v=0; with HAZ_PERF_EN both perf counters read 0.

Source files
------------

// File: rtl/hazard_ctrl_multi.sv
//-----------------------------------------------------------------------------
// hazard_ctrl_multi
//
// N-lane hazard controller for the superscalar 5-stage pipeline. It sits
// beside the pipeline registers and produces every stall, flush, squash and
// forwarding select. It also keeps a one-entry scoreboard for a single
// outstanding fixed-latency long op (mul/div).
//
// Parameters
//   LANES     issue width; lane 0 is the oldest instruction in a bundle
//   LONG_LAT  long-op latency in cycles, legal range 2..15
//   LW        source-lane field width, derived from LANES (not overridable)
//
// Ports
//   clk, rst_n                        clock, synchronous active-low reset
//   rs1_d, rs2_d, rd_d                D-stage sources/destination, lane i at [5i+:5]
//   rs1_e, rs2_e, rd_e                E-stage sources/destination
//   rd_m, rd_w                        M/W-stage destinations
//   regwrite_e/_m/_w                  per-lane write enables
//   is_load_e, long_e, br_taken_e     per-lane E-stage instruction class
//   mem_wait                          data memory not ready
//   fwd_a_e, fwd_b_e                  per lane {src_lane[LW-1:0], stage[1:0]}
//                                     stage: 00 RF, 10 M, 01 W
//   stall_f/_d/_e/_m                  hold the stage register
//   flush_d/_e/_w                     bubble into the stage register
//   squash_e                          kill E lanes younger than the taken branch
//   br_lane                           index of the oldest taken branch lane
//   long_done, long_rd                long result valid / its destination
//   perf_stall_cyc, perf_flush_cnt    only when HAZ_PERF_EN is defined
//
// Configuration
//   HAZ_PERF_EN  adds two free-running 32-bit performance counters.
//-----------------------------------------------------------------------------
module hazard_ctrl_multi #(
    parameter int  LANES    = 2,
    parameter int  LONG_LAT = 4,
    localparam int LW       = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LANES*5-1:0]        rs1_d,
    input  logic [LANES*5-1:0]        rs2_d,
    input  logic [LANES*5-1:0]        rd_d,
    input  logic [LANES*5-1:0]        rs1_e,
    input  logic [LANES*5-1:0]        rs2_e,
    input  logic [LANES*5-1:0]        rd_e,
    input  logic [LANES*5-1:0]        rd_m,
    input  logic [LANES*5-1:0]        rd_w,
    input  logic [LANES-1:0]          regwrite_e,
    input  logic [LANES-1:0]          regwrite_m,
    input  logic [LANES-1:0]          regwrite_w,
    input  logic [LANES-1:0]          is_load_e,
    input  logic [LANES-1:0]          long_e,
    input  logic [LANES-1:0]          br_taken_e,
    input  logic                      mem_wait,
    output logic [LANES*(2+LW)-1:0]   fwd_a_e,
    output logic [LANES*(2+LW)-1:0]   fwd_b_e,
    output logic                      stall_f,
    output logic                      stall_d,
    output logic                      stall_e,
    output logic                      stall_m,
    output logic                      flush_d,
    output logic                      flush_e,
    output logic                      flush_w,
    output logic [LANES-1:0]          squash_e,
    output logic [LW-1:0]             br_lane,
    output logic                      long_done,
    output logic [4:0]                long_rd
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0]               perf_stall_cyc,
    output logic [31:0]               perf_flush_cnt
`endif
);

    localparam int         FW     = 2 + LW;
    localparam logic [1:0] SEL_RF = 2'b00;
    localparam logic [1:0] SEL_M  = 2'b10;
    localparam logic [1:0] SEL_W  = 2'b01;

    //-------------------------------------------------------------------------
    // Scoreboard state for the single outstanding long op
    //-------------------------------------------------------------------------
    logic       busy_v;
    logic [4:0] busy_rd;
    logic [3:0] cnt;

    //-------------------------------------------------------------------------
    // Forwarding select for one operand.
    // Both scans run lane 0 upwards so the youngest matching lane is the last
    // assignment; the M scan runs after the W scan so any M hit overrides.
    //-------------------------------------------------------------------------
    function automatic logic [FW-1:0] fwd_sel(
        input logic [4:0]         rs,
        input logic [LANES*5-1:0] rd_mv,
        input logic [LANES-1:0]   we_m,
        input logic [LANES*5-1:0] rd_wv,
        input logic [LANES-1:0]   we_w
    );
        logic [FW-1:0] sel;
        sel = {{LW{1'b0}}, SEL_RF};
        if (rs != 5'd0) begin
            for (int i = 0; i < LANES; i++) begin
                if (we_w[i] && (rd_wv[5*i +: 5] == rs))
                    sel = {LW'(i), SEL_W};
            end
            for (int i = 0; i < LANES; i++) begin
                if (we_m[i] && (rd_mv[5*i +: 5] == rs))
                    sel = {LW'(i), SEL_M};
            end
        end
        return sel;
    endfunction

    logic [LANES*FW-1:0] fwd_a_raw;
    logic [LANES*FW-1:0] fwd_b_raw;

    // NOTE: every variable assigned in an always_comb gets a default at the
    // top of the block, so no path can leave it unassigned and infer a latch.
    always_comb begin
        fwd_a_raw = '0;
        fwd_b_raw = '0;
        for (int j = 0; j < LANES; j++) begin
            fwd_a_raw[FW*j +: FW] = fwd_sel(rs1_e[5*j +: 5], rd_m, regwrite_m, rd_w, regwrite_w);
            fwd_b_raw[FW*j +: FW] = fwd_sel(rs2_e[5*j +: 5], rd_m, regwrite_m, rd_w, regwrite_w);
        end
    end

    //-------------------------------------------------------------------------
    // Branch resolution: oldest taken lane and the younger-lane kill mask
    //-------------------------------------------------------------------------
    logic             any_br;
    logic [LW-1:0]    br_idx;
    logic [LANES-1:0] squash_mask;

    always_comb begin
        logic seen;
        any_br      = |br_taken_e;
        br_idx      = '0;
        squash_mask = '0;
        seen        = 1'b0;
        // Downward scan: the last hit is the lowest (oldest) taken lane.
        for (int i = LANES - 1; i >= 0; i--) begin
            if (br_taken_e[i])
                br_idx = LW'(i);
        end
        // Upward scan: every lane after the first taken one is younger.
        for (int i = 0; i < LANES; i++) begin
            if (seen)
                squash_mask[i] = 1'b1;
            if (br_taken_e[i])
                seen = 1'b1;
        end
    end

    //-------------------------------------------------------------------------
    // Stall sources
    //-------------------------------------------------------------------------
    logic struct_hz;   // second long op while the unit is still busy
    logic sb_hz;       // D instruction touches the pending long-op register
    logic lu_hz;       // D consumer of a load currently in E

    always_comb begin
        struct_hz = (|long_e) && busy_v && (cnt > 4'd1);
        sb_hz     = 1'b0;
        lu_hz     = 1'b0;
        for (int j = 0; j < LANES; j++) begin
            if (busy_v && (busy_rd != 5'd0) &&
                ((rs1_d[5*j +: 5] == busy_rd) ||
                 (rs2_d[5*j +: 5] == busy_rd) ||
                 (rd_d[5*j +: 5]  == busy_rd)))
                sb_hz = 1'b1;
            for (int i = 0; i < LANES; i++) begin
                if (is_load_e[i] && (rd_e[5*i +: 5] != 5'd0) &&
                    ((rs1_d[5*j +: 5] == rd_e[5*i +: 5]) ||
                     (rs2_d[5*j +: 5] == rd_e[5*i +: 5])))
                    lu_hz = 1'b1;
            end
        end
    end

    // Priority decode: memory wait, then taken branch, then ordinary stalls.
    logic p1_act;
    logic p2_act;
    logic p3_act;
    logic struct_stall;

    assign p1_act       = mem_wait;
    assign p2_act       = !mem_wait && any_br;
    assign p3_act       = !mem_wait && !any_br && (struct_hz || sb_hz || lu_hz);
    assign struct_stall = p3_act && struct_hz;

    //-------------------------------------------------------------------------
    // Scoreboard load candidate: oldest surviving long op that writes a reg
    //-------------------------------------------------------------------------
    logic       load_hit;
    logic [4:0] load_rd;
    logic       load_en;

    always_comb begin
        load_hit = 1'b0;
        load_rd  = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (long_e[i] && regwrite_e[i] && (rd_e[5*i +: 5] != 5'd0) && !squash_mask[i]) begin
                load_hit = 1'b1;
                load_rd  = rd_e[5*i +: 5];
            end
        end
    end

    assign load_en = load_hit && !p1_act && !struct_stall;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_v  <= 1'b0;
            busy_rd <= 5'd0;
            cnt     <= 4'd0;
        end else if (!p1_act) begin
            if (load_en) begin
                // A load at the completion edge replaces the finishing op.
                busy_v  <= 1'b1;
                busy_rd <= load_rd;
                cnt     <= 4'(LONG_LAT);
            end else begin
                if (cnt != 4'd0)
                    cnt <= cnt - 4'd1;
                if (busy_v && (cnt == 4'd1))
                    busy_v <= 1'b0;
            end
        end
    end

    //-------------------------------------------------------------------------
    // Output drive; reset overrides everything with a flushed, idle pipeline
    //-------------------------------------------------------------------------
    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        stall_m  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        flush_w  = 1'b0;
        squash_e = '0;
        if (!rst_n) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (p1_act) begin
            // Whole pipe frozen; W gets a bubble so the stalled M result is
            // not written twice.
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (p2_act) begin
            flush_d  = 1'b1;
            flush_e  = 1'b1;
            squash_e = squash_mask;
        end else if (p3_act) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            // A structural stall keeps the waiting long op in E rather than
            // dropping it.
            if (struct_hz)
                stall_e = 1'b1;
            else
                flush_e = 1'b1;
        end
    end

    assign fwd_a_e   = rst_n ? fwd_a_raw : '0;
    assign fwd_b_e   = rst_n ? fwd_b_raw : '0;
    assign br_lane   = rst_n ? br_idx : '0;
    assign long_done = rst_n && busy_v && (cnt == 4'd1);
    assign long_rd   = long_done ? busy_rd : 5'd0;

    //-------------------------------------------------------------------------
    // Optional performance counters
    //-------------------------------------------------------------------------
`ifdef HAZ_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cyc <= 32'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            if (p1_act || p3_act)
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            if (p2_act)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`else
    // No performance counters in this build.
`endif

endmodule

// File: tb/tb_hazard_ctrl_multi.sv
//-----------------------------------------------------------------------------
// tb_hazard_ctrl_multi
//
// Self-checking bench for hazard_ctrl_multi with LANES=2, LONG_LAT=4.
// Combinational priority/forwarding behaviour is driven from a table of
// vectors; the scoreboard timing is exercised by hand-written sequences.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
//-----------------------------------------------------------------------------
module tb_hazard_ctrl_multi;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0] regwrite_e, regwrite_m, regwrite_w, is_load_e, long_e, br_taken_e;
    logic       mem_wait;
    logic [5:0] fwd_a_e, fwd_b_e;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_w;
    logic [1:0] squash_e;
    logic [0:0] br_lane;
    logic       long_done;
    logic [4:0] long_rd;
`ifdef HAZ_PERF_EN
    logic [31:0] perf_stall_cyc, perf_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl_multi #(.LANES(2), .LONG_LAT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs1_d      (rs1_d),
        .rs2_d      (rs2_d),
        .rd_d       (rd_d),
        .rs1_e      (rs1_e),
        .rs2_e      (rs2_e),
        .rd_e       (rd_e),
        .rd_m       (rd_m),
        .rd_w       (rd_w),
        .regwrite_e (regwrite_e),
        .regwrite_m (regwrite_m),
        .regwrite_w (regwrite_w),
        .is_load_e  (is_load_e),
        .long_e     (long_e),
        .br_taken_e (br_taken_e),
        .mem_wait   (mem_wait),
        .fwd_a_e    (fwd_a_e),
        .fwd_b_e    (fwd_b_e),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .stall_e    (stall_e),
        .stall_m    (stall_m),
        .flush_d    (flush_d),
        .flush_e    (flush_e),
        .flush_w    (flush_w),
        .squash_e   (squash_e),
        .br_lane    (br_lane),
        .long_done  (long_done),
        .long_rd    (long_rd)
`ifdef HAZ_PERF_EN
        ,
        .perf_stall_cyc (perf_stall_cyc),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    typedef struct packed {
        logic [9:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
        logic [1:0] regwrite_m, regwrite_w, is_load_e, br_taken_e;
        logic       mem_wait;
        logic [5:0] x_fwd_a, x_fwd_b;
        logic [3:0] x_stall;    // {f,d,e,m}
        logic [2:0] x_flush;    // {d,e,w}
        logic [1:0] x_squash;
        logic       x_br_lane;
    } vec_t;

    vec_t vecs[$];

    // Pack two lane register numbers, lane 0 in the low bits.
    function automatic logic [9:0] pk(input logic [4:0] l0, input logic [4:0] l1);
        return {l1, l0};
    endfunction

    // One lane's forwarding field: {source lane, stage}.
    function automatic logic [2:0] fe(input logic lane, input logic [1:0] st);
        return {lane, st};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        rs1_d = '0; rs2_d = '0; rd_d = '0;
        rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
        regwrite_e = '0; regwrite_m = '0; regwrite_w = '0;
        is_load_e = '0; long_e = '0; br_taken_e = '0; mem_wait = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        rs1_d = v.rs1_d; rs2_d = v.rs2_d; rd_d = v.rd_d;
        rs1_e = v.rs1_e; rs2_e = v.rs2_e; rd_e = v.rd_e;
        rd_m = v.rd_m; rd_w = v.rd_w;
        regwrite_e = '0; long_e = '0;
        regwrite_m = v.regwrite_m; regwrite_w = v.regwrite_w;
        is_load_e = v.is_load_e; br_taken_e = v.br_taken_e; mem_wait = v.mem_wait;
    endtask

    // One cycle of reset, then release; leaves the bench at a falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Put a long op writing rd 9 into E lane 0 with a D consumer of r9.
    task automatic issue_long9();
        @(negedge clk);
        long_e = 2'b01; regwrite_e = 2'b01; rd_e = pk(9, 0); rs1_d = pk(9, 0);
    endtask

    task automatic clear_long();
        long_e = '0; regwrite_e = '0; rd_e = '0;
    endtask

    initial begin
        vec_t v;

        //---------------------------------------------------------------------
        // Vector table
        //---------------------------------------------------------------------
        v = '0;                                              // v0 quiet
        vecs.push_back(v);

        v = '0;                                              // v1 both M lanes hit, youngest wins
        v.rs1_e = pk(0, 5); v.rd_m = pk(5, 5); v.regwrite_m = 2'b11;
        v.x_fwd_a = {fe(1'b1, 2'b10), fe(1'b0, 2'b00)};
        vecs.push_back(v);

        v = '0;                                              // v2 unwritten M ignored, W used; M beats W
        v.rs1_e = pk(4, 0); v.rs2_e = pk(3, 0);
        v.rd_m = pk(3, 4); v.regwrite_m = 2'b01;
        v.rd_w = pk(4, 3); v.regwrite_w = 2'b11;
        v.x_fwd_a = {3'b000, fe(1'b0, 2'b01)};
        v.x_fwd_b = {3'b000, fe(1'b0, 2'b10)};
        vecs.push_back(v);

        v = '0;                                              // v3 r0 written in M ignored, W youngest
        v.rs1_e = pk(0, 8); v.rs2_e = pk(0, 8);
        v.rd_m = pk(0, 0); v.regwrite_m = 2'b11;
        v.rd_w = pk(8, 8); v.regwrite_w = 2'b11;
        v.x_fwd_a = {fe(1'b1, 2'b01), 3'b000};
        v.x_fwd_b = {fe(1'b1, 2'b01), 3'b000};
        vecs.push_back(v);

        v = '0;                                              // v4 load-use lane0 load -> lane1 rs2
        v.is_load_e = 2'b01; v.rd_e = pk(7, 0); v.rs2_d = pk(0, 7);
        v.x_stall = 4'b1100; v.x_flush = 3'b010;
        vecs.push_back(v);

        v = '0;                                              // v5 load to r0 never stalls
        v.is_load_e = 2'b01; v.rd_e = pk(0, 0);
        vecs.push_back(v);

        v = '0;                                              // v6 ALU producer in E is forwarded, no stall
        v.rd_e = pk(0, 6); v.rs1_d = pk(6, 0);
        vecs.push_back(v);

        v = '0;                                              // v7 branch beats load-use
        v.is_load_e = 2'b01; v.rd_e = pk(7, 0); v.rs2_d = pk(0, 7); v.br_taken_e = 2'b11;
        v.x_flush = 3'b110; v.x_squash = 2'b10; v.x_br_lane = 1'b0;
        vecs.push_back(v);

        v = '0;                                              // v8 branch in youngest lane only
        v.br_taken_e = 2'b10;
        v.x_flush = 3'b110; v.x_br_lane = 1'b1;
        vecs.push_back(v);

        v = '0;                                              // v9 mem_wait beats branch and load-use
        v.is_load_e = 2'b01; v.rd_e = pk(7, 0); v.rs2_d = pk(0, 7);
        v.br_taken_e = 2'b10; v.mem_wait = 1'b1;
        v.x_stall = 4'b1111; v.x_flush = 3'b001; v.x_br_lane = 1'b1;
        vecs.push_back(v);

        v = '0;                                              // v10 forwarding unaffected by mem_wait
        v.mem_wait = 1'b1; v.rs1_e = pk(9, 0); v.rd_m = pk(0, 9); v.regwrite_m = 2'b10;
        v.x_fwd_a = {3'b000, fe(1'b1, 2'b10)};
        v.x_stall = 4'b1111; v.x_flush = 3'b001;
        vecs.push_back(v);

        v = '0;                                              // v11 load lane1 -> lane0 rs1
        v.is_load_e = 2'b10; v.rd_e = pk(0, 12); v.rs1_d = pk(12, 0);
        v.x_stall = 4'b1100; v.x_flush = 3'b010;
        vecs.push_back(v);

        v = '0;                                              // v12 older M lane beats younger W lane
        v.rs2_e = pk(0, 14); v.rd_m = pk(14, 0); v.regwrite_m = 2'b01;
        v.rd_w = pk(0, 14); v.regwrite_w = 2'b10;
        v.x_fwd_b = {fe(1'b0, 2'b10), 3'b000};
        vecs.push_back(v);

        //---------------------------------------------------------------------
        // Reset: outputs forced even with hazards present on the inputs
        //---------------------------------------------------------------------
        idle();
        mem_wait = 1'b1; br_taken_e = 2'b11;
        rs1_e = pk(5, 5); rd_m = pk(5, 5); regwrite_m = 2'b11;
        @(negedge clk); #1;
        check("rst stalls",    {stall_f, stall_d, stall_e, stall_m}, 4'b0000);
        check("rst flushes",   {flush_d, flush_e, flush_w}, 3'b110);
        check("rst fwd_a",     fwd_a_e, 6'd0);
        check("rst squash",    squash_e, 2'b00);
        check("rst br_lane",   br_lane, 1'b0);
        check("rst long_done", long_done, 1'b0);
        check("rst long_rd",   long_rd, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        //---------------------------------------------------------------------
        // Table
        //---------------------------------------------------------------------
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            check($sformatf("v%0d fwd_a", i),   fwd_a_e, vecs[i].x_fwd_a);
            check($sformatf("v%0d fwd_b", i),   fwd_b_e, vecs[i].x_fwd_b);
            check($sformatf("v%0d stall", i),   {stall_f, stall_d, stall_e, stall_m}, vecs[i].x_stall);
            check($sformatf("v%0d flush", i),   {flush_d, flush_e, flush_w}, vecs[i].x_flush);
            check($sformatf("v%0d squash", i),  squash_e, vecs[i].x_squash);
            check($sformatf("v%0d br_lane", i), br_lane, vecs[i].x_br_lane);
        end
        @(negedge clk);
        idle();

        //---------------------------------------------------------------------
        // Long op rd 9 with a waiting consumer: stall t+1..t+4, done at t+4
        //---------------------------------------------------------------------
        do_reset();
        issue_long9();
        #1 check("lat t stall_d", stall_d, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            clear_long();
            #1;
            check($sformatf("lat t+%0d stall_d", k),   stall_d,   (k <= 4));
            check($sformatf("lat t+%0d long_done", k), long_done, (k == 4));
            check($sformatf("lat t+%0d long_rd", k),   long_rd,   (k == 4) ? 5'd9 : 5'd0);
        end

        //---------------------------------------------------------------------
        // mem_wait for cycles t+2..t+4 pushes completion to t+7
        //---------------------------------------------------------------------
        do_reset();
        issue_long9();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            clear_long();
            mem_wait = (k >= 2 && k <= 4);
            #1;
            check($sformatf("mw t+%0d stall_m", k),   stall_m,   (k >= 2 && k <= 4));
            check($sformatf("mw t+%0d flush_w", k),   flush_w,   (k >= 2 && k <= 4));
            check($sformatf("mw t+%0d stall_d", k),   stall_d,   (k <= 7));
            check($sformatf("mw t+%0d flush_e", k),   flush_e,   (k == 1) || (k >= 5 && k <= 7));
            check($sformatf("mw t+%0d long_done", k), long_done, (k == 7));
        end
        mem_wait = 1'b0;

        //---------------------------------------------------------------------
        // Structural stall, then a new op loading at the completion edge
        //---------------------------------------------------------------------
        do_reset();
        @(negedge clk);
        long_e = 2'b01; regwrite_e = 2'b01; rd_e = pk(9, 0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                long_e = 2'b10; regwrite_e = 2'b10; rd_e = pk(0, 10); rd_d = '0;
            end else begin
                clear_long(); rd_d = pk(0, 10);
            end
            #1;
            check($sformatf("st t+%0d stall_e", k),   stall_e,   (k <= 3));
            check($sformatf("st t+%0d flush_e", k),   flush_e,   (k >= 5 && k <= 8));
            check($sformatf("st t+%0d stall_d", k),   stall_d,   (k <= 3) || (k >= 5 && k <= 8));
            check($sformatf("st t+%0d long_done", k), long_done, (k == 4) || (k == 8));
            check($sformatf("st t+%0d long_rd", k),   long_rd,
                  (k == 4) ? 5'd9 : ((k == 8) ? 5'd10 : 5'd0));
        end
        idle();

        //---------------------------------------------------------------------
        // Long op in a squashed lane never enters the scoreboard
        //---------------------------------------------------------------------
        do_reset();
        @(negedge clk);
        br_taken_e = 2'b01; long_e = 2'b10; regwrite_e = 2'b10; rd_e = pk(0, 11);
        #1 check("sq t squash", squash_e, 2'b10);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            idle();
            rs1_d = pk(11, 0);
            #1;
            check($sformatf("sq t+%0d stall_d", k),   stall_d,   1'b0);
            check($sformatf("sq t+%0d long_done", k), long_done, 1'b0);
        end

        //---------------------------------------------------------------------
        // Reset in the middle of a long op drops the completion
        //---------------------------------------------------------------------
        do_reset();
        issue_long9();
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            clear_long();
            rst_n = (k != 2);
            #1;
            check($sformatf("rm t+%0d stall_d", k),   stall_d,   (k == 1));
            check($sformatf("rm t+%0d long_done", k), long_done, 1'b0);
`ifdef HAZ_PERF_EN
            if (k == 3) begin
                check("rm perf_stall", perf_stall_cyc, 32'd0);
                check("rm perf_flush", perf_flush_cnt, 32'd0);
            end
`endif
        end
        rst_n = 1'b1;

`ifdef HAZ_PERF_EN
        //---------------------------------------------------------------------
        // One mem_wait cycle and one branch cycle each count once
        //---------------------------------------------------------------------
        do_reset();
        @(negedge clk);
        idle(); mem_wait = 1'b1;
        @(negedge clk);
        idle(); br_taken_e = 2'b01;
        @(negedge clk);
        idle();
        #1;
        check("perf stall count", perf_stall_cyc, 32'd1);
        check("perf flush count", perf_flush_cnt, 32'd1);
`endif

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
